// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding, the NOP word and opcodes
// that are common to the fetch stage and the hazard detection unit.
package cpu_pkg;

  typedef enum logic [1:0] {
    FS_RUN   = 2'd0,
    FS_STALL = 2'd1,
    FS_FLUSH = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [5:0]  beqOPcode = 6'b000100;

  // Instruction addresses are word aligned; low two bits are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Free-running event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (v == {W{1'b1}}) ? v : v + W'(1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC select, IF/ID register,
// stall/flush handling and saturating performance counters.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             holdPC,
  input  logic             holdIF_ID,
  input  logic             branchTaken,
  input  logic [31:0]      branchTarget,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      IF_ID_Instr,
  output logic [31:0]      IF_ID_PC4,
  output logic             IF_ID_Valid,
  output logic [1:0]       fetchState,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount,
  output logic             misalignErr
);

  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic         hold;
  logic         stall_inc;
  fetch_state_e state_q;

  // PC and IF/ID always freeze together so a one-sided hold cannot drop
  // or duplicate an instruction.
  assign hold       = holdPC | holdIF_ID;
  assign stall_inc  = hold & ~branchTaken;
  assign pc_plus4   = pc + 32'd4;
  assign imem_addr  = pc;
  assign fetchState = state_q;

  // IF -> IF/ID boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      IF_ID_Instr <= NOP_INSTR;
      IF_ID_PC4   <= '0;
      IF_ID_Valid <= 1'b0;
    end else if (branchTaken) begin
      pc          <= align_word(branchTarget);
      IF_ID_Instr <= NOP_INSTR;
      IF_ID_Valid <= 1'b0;
    end else if (!hold) begin
      pc          <= pc_plus4;
      IF_ID_Instr <= imem_rdata;
      IF_ID_PC4   <= pc_plus4;
      IF_ID_Valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FS_RUN;
      misalignErr <= 1'b0;
    end else if (branchTaken) begin
      state_q <= FS_FLUSH;
      if (branchTarget[1:0] != 2'b00) begin
        misalignErr <= 1'b1;
      end
    end else if (hold) begin
      state_q <= FS_STALL;
    end else begin
      state_q <= FS_RUN;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stallCount)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (branchTaken),
    .count (flushCount)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a wide-counter and a 2-bit-counter
// instance share stimulus and are checked against a behavioural model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        holdPC, holdIF_ID, branchTaken;
  logic [31:0] branchTarget;

  logic [31:0] imem_addr, imem_rdata, IF_ID_Instr, IF_ID_PC4;
  logic        IF_ID_Valid, misalignErr;
  logic [1:0]  fetchState;
  logic [15:0] stallCount, flushCount;

  logic [31:0] imem_addr_s, imem_rdata_s, IF_ID_Instr_s, IF_ID_PC4_s;
  logic        IF_ID_Valid_s, misalignErr_s;
  logic [1:0]  fetchState_s;
  logic [1:0]  stallCount_s, flushCount_s;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + a;
  endfunction

  assign imem_rdata   = mem_word(imem_addr);
  assign imem_rdata_s = mem_word(imem_addr_s);

  fetch_stage #(.RESET_PC(32'h0), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .holdPC(holdPC), .holdIF_ID(holdIF_ID),
    .branchTaken(branchTaken), .branchTarget(branchTarget),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .IF_ID_Instr(IF_ID_Instr), .IF_ID_PC4(IF_ID_PC4), .IF_ID_Valid(IF_ID_Valid),
    .fetchState(fetchState), .stallCount(stallCount), .flushCount(flushCount),
    .misalignErr(misalignErr)
  );

  fetch_stage #(.RESET_PC(32'h0), .CNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .holdPC(holdPC), .holdIF_ID(holdIF_ID),
    .branchTaken(branchTaken), .branchTarget(branchTarget),
    .imem_addr(imem_addr_s), .imem_rdata(imem_rdata_s),
    .IF_ID_Instr(IF_ID_Instr_s), .IF_ID_PC4(IF_ID_PC4_s), .IF_ID_Valid(IF_ID_Valid_s),
    .fetchState(fetchState_s), .stallCount(stallCount_s), .flushCount(flushCount_s),
    .misalignErr(misalignErr_s)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [1:0]  st;
    int          stall;
    int          flush;
    logic        mis;
    int          stall2;
    int          flush2;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  exp_t m;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input exp_t e, input string tag);
    cmp({tag, " imem_addr"},    imem_addr, e.pc);
    cmp({tag, " IF_ID_Instr"},  IF_ID_Instr, e.instr);
    cmp({tag, " IF_ID_PC4"},    IF_ID_PC4, e.pc4);
    cmp({tag, " IF_ID_Valid"},  32'(IF_ID_Valid), 32'(e.valid));
    cmp({tag, " fetchState"},   32'(fetchState), 32'(e.st));
    cmp({tag, " stallCount"},   32'(stallCount), e.stall);
    cmp({tag, " flushCount"},   32'(flushCount), e.flush);
    cmp({tag, " misalignErr"},  32'(misalignErr), 32'(e.mis));
    cmp({tag, " small stall"},  32'(stallCount_s), e.stall2);
    cmp({tag, " small flush"},  32'(flushCount_s), e.flush2);
    cmp({tag, " small imem"},   imem_addr_s, e.pc);
  endtask

  function automatic exp_t model_reset();
    exp_t r;
    r.pc = 32'h0; r.instr = 32'h0; r.pc4 = 32'h0; r.valid = 1'b0; r.st = 2'd0;
    r.stall = 0; r.flush = 0; r.mis = 1'b0; r.stall2 = 0; r.flush2 = 0;
    return r;
  endfunction

  // Reference behaviour: priority branch > hold > normal; counters cap at max.
  function automatic exp_t model_step(input exp_t s, input logic h, input logic b,
                                      input logic [31:0] tgt);
    exp_t n = s;
    if (b) begin
      n.pc    = (tgt / 4) * 4;
      n.instr = 32'h0;
      n.valid = 1'b0;
      n.st    = 2'd2;
      if (n.flush < 65535) n.flush++;
      if (n.flush2 < 3) n.flush2++;
      if (tgt % 4 != 0) n.mis = 1'b1;
    end else if (h) begin
      n.st = 2'd1;
      if (n.stall < 65535) n.stall++;
      if (n.stall2 < 3) n.stall2++;
    end else begin
      n.instr = mem_word(s.pc);
      n.pc4   = s.pc + 32'd4;
      n.pc    = s.pc + 32'd4;
      n.valid = 1'b1;
      n.st    = 2'd0;
    end
    return n;
  endfunction

  // Called at a falling edge; leaves the bench at the next falling edge.
  task automatic step(input logic hp, input logic hi, input logic b, input logic [31:0] tgt);
    holdPC = hp; holdIF_ID = hi; branchTaken = b; branchTarget = tgt;
    m = model_step(m, hp | hi, b, tgt);
    sb.push_back(m);
    @(negedge clk);
  endtask

  task automatic async_reset();
    holdPC = 1'b0; holdIF_ID = 1'b0; branchTaken = 1'b0; branchTarget = 32'h0;
    #2 reset = 1'b1;
    #1;
    m = model_reset();
    check_all(m, "async reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      check_all(mon_e, "edge");
    end
  end

  initial begin
    reset = 1'b1;
    holdPC = 1'b0; holdIF_ID = 1'b0; branchTaken = 1'b0; branchTarget = 32'h0;
    m = model_reset();
    @(negedge clk);
    check_all(m, "reset");
    reset = 1'b0;

    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 32'h0);

    async_reset();
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h40);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h42);
    step(1'b0, 1'b0, 1'b1, 32'h80);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 32'h0);

    async_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);

    async_reset();
    step(1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8);
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0);

    for (int i = 0; i < 400; i++) begin
      logic hp, hi, b;
      logic [31:0] tgt;
      hp  = ($urandom_range(0, 3) == 0);
      hi  = ($urandom_range(0, 3) == 0);
      b   = ($urandom_range(0, 5) == 0);
      tgt = $urandom;
      if ($urandom_range(0, 1) == 0) tgt[1:0] = 2'b00;
      step(hp, hi, b, tgt);
      if (i == 200) async_reset();
    end

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline. It sits directly upstream of the hazard detection unit and owns the PC register, the next-PC select and the IF/ID pipeline register. It applies the hazard unit's holdPC/holdIF_ID stall requests and redirects to the branch target on a taken beq, inserting a bubble. It also keeps saturating stall and flush counters for performance checks.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
CNT_W, 16, width of the stall and flush counters.

Ports:
clk  in  1  pipeline clock; all state updates on the rising edge
reset  in  1  asynchronous, active-high reset
holdPC  in  1  stall request from the hazard detection unit: freeze PC
holdIF_ID  in  1  stall request from the hazard detection unit: freeze the IF/ID register
branchTaken  in  1  taken-branch redirect from the branch resolution logic
branchTarget  in  32  redirect address, valid while branchTaken=1
imem_addr  out  32  instruction memory address (combinational read)
imem_rdata  in  32  instruction word at imem_addr, same cycle
IF_ID_Instr  out  32  registered instruction, consumed by decode and the hazard unit
IF_ID_PC4  out  32  registered PC+4 of IF_ID_Instr
IF_ID_Valid  out  1  1 = IF_ID_Instr is a real instruction; 0 = bubble
fetchState  out  2  current FSM state: 0 RUN, 1 STALL, 2 FLUSH
stallCount  out  CNT_W  number of cycles with a stall applied, saturating
flushCount  out  CNT_W  number of redirects taken, saturating
misalignErr  out  1  sticky flag: a branch target had bits [1:0] != 0

Behaviour:
- Reset is asynchronous and active-high, with one clock.
  - On reset: PC=RESET_PC, IF_ID_Instr=32'h0 (NOP), IF_ID_PC4=0, IF_ID_Valid=0.
  - Also on reset: fetchState=RUN, stallCount=0, flushCount=0, misalignErr=0.
  - Reset asserted mid-stall or mid-flush discards everything. The first fetch after release is from RESET_PC.
- imem_addr = PC, combinational. Fetch latency is 1 cycle: the word at PC appears on IF_ID_Instr one edge later.
- hold = holdPC | holdIF_ID. PC and the IF/ID register always freeze together, so a one-sided hold never drops or duplicates an instruction.
- Per-edge priority: reset > branchTaken > hold > normal.
- Normal case:
  - PC <= PC+4, wrapping modulo 2^32.
  - IF_ID_Instr <= imem_rdata, IF_ID_PC4 <= PC+4, IF_ID_Valid <= 1.
  - fetchState <= RUN.
- Hold case (no branchTaken):
  - PC and all IF_ID_* outputs are unchanged.
  - stallCount increments, saturating at all-ones.
  - fetchState <= STALL.
- branchTaken case (overrides hold):
  - PC <= {branchTarget[31:2],2'b00}.
  - IF_ID_Instr <= 0, IF_ID_Valid <= 0, IF_ID_PC4 unchanged.
  - flushCount increments, saturating. fetchState <= FLUSH.
  - If branchTarget[1:0] != 0, misalignErr <= 1; it is cleared only by reset.
- FSM transitions, evaluated each edge from the inputs:
  - Any state -> FLUSH on branchTaken.
  - Otherwise any state -> STALL on hold.
  - Otherwise -> RUN.
  - FLUSH lasts exactly one cycle unless branchTaken repeats. Back-to-back branchTaken redirects each time and counts each one.
- FLUSH with hold asserted in the next cycle: STALL holds the bubble. IF_ID_Valid stays 0 until the first non-hold edge.
- The counters are free-running; they stop at 2^CNT_W-1 and never wrap.

Decomposition:
- Shared package cpu_pkg holds:
  - fetch-state constants FS_RUN=2'd0, FS_STALL=2'd1, FS_FLUSH=2'd2;
  - NOP_INSTR=32'h0;
  - beqOPcode=6'b000100, shared with the hazard detection unit.
- One sub-module: sat_counter (parameter W; ports clk, reset, inc, count). It is instantiated twice, for stallCount and flushCount.

Test Plan:
- Reset, then 4 idle cycles with imem_rdata = 32'h1000_0000+addr -> IF_ID_PC4 = 4,8,12,16 in turn; IF_ID_Valid=1 from the first edge; imem_addr=16 after 4 edges.
- holdPC=holdIF_ID=1 for 3 cycles with PC=8 -> imem_addr stays 8; IF_ID_* unchanged; fetchState=STALL; stallCount=3; fetch resumes at 8 after release.
- holdIF_ID=1, holdPC=0 for 1 cycle -> PC also frozen; no instruction lost (the sequence of IF_ID_PC4 values has no gap).
- branchTaken=1, branchTarget=32'h40 while hold=1 -> next edge PC=0x40, IF_ID_Valid=0, fetchState=FLUSH, flushCount=1, stallCount unchanged.
- branchTarget=32'h42 -> PC=0x40 and misalignErr=1, still 1 after 10 cycles; reset asserted mid-cycle (asynchronously) -> immediately PC=RESET_PC, misalignErr=0, counters=0.
- Force CNT_W=2 and apply 6 hold cycles -> stallCount reaches 3 and stays at 3.
